// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Contents: common word types (u64, u32), fetch FSM state enum, next-PC
// select enum, fetch buffer payload struct, reset PC and misalignment helper.
package fetch_unit_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INST_W = 32;

    typedef logic [XLEN-1:0]   u64;
    typedef logic [INST_W-1:0] u32;

    localparam u64 PC_RESET = 64'h0000_0000_8000_0000;
    localparam u64 PC_STEP  = 64'd4;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        FULL = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2,
        PC_PEND  = 2'd3
    } pc_sel_t;

    typedef struct packed {
        logic valid;
        u64   pc;
        u32   instr;
        logic exc;
    } fetch_data_t;

    // Instructions are 4-byte aligned; any low bit set is a misaligned PC.
    function automatic logic pc_misaligned(input u64 pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-bus request/response interface.
// Signals: ireq_valid/ireq_addr (request, driven by the fetch unit),
// iresp_data_ok/iresp_data (response beat, driven by the memory side).
// Modports: master = fetch unit, slave = instruction memory / bus.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic ireq_valid;
    u64   ireq_addr;
    logic iresp_data_ok;
    u32   iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_unit_pcselect.sv
// Next fetch-PC multiplexer (combinational).
// Ports: sel (which source), pc_q (current PC), redirect_pc (hazard-unit
// target), pend_q (target latched while a stale request drains),
// pc_next_c (selected next PC; increment wraps modulo 2^XLEN).
module fetch_unit_pcselect
    import fetch_unit_pkg::*;
(
    input  pc_sel_t sel,
    input  u64      pc_q,
    input  u64      redirect_pc,
    input  u64      pend_q,
    output u64      pc_next_c
);

    always_comb begin
        pc_next_c = pc_q;
        unique case (sel)
            PC_INC:   pc_next_c = pc_q + PC_STEP;
            PC_REDIR: pc_next_c = redirect_pc;
            PC_PEND:  pc_next_c = pend_q;
            default:  pc_next_c = pc_q;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs the instruction-bus
// handshake, applies redirects/flushes from the hazard unit and presents one
// instruction at a time to IF/ID.
// Ports: clk, reset (async, active-high); redirect_valid/redirect_pc (branch,
// JAL, JALR target); flush (drop buffered instruction, keep PC); id_ready
// (IF/ID accepts); ibus (instruction-bus master); fetch_valid/fetch_pc/
// fetch_instr/fetch_exc (presented instruction).
// Optional: define FETCH_MISALIGN_CHECK_EN to turn a misaligned PC into a
// fetch_exc entry instead of a bus request; otherwise fetch_exc is constant 0.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect_valid,
    input  u64            redirect_pc,
    input  logic          flush,
    input  logic          id_ready,
    fetch_unit_if.master  ibus,
    output logic          fetch_valid,
    output u64            fetch_pc,
    output u32            fetch_instr,
    output logic          fetch_exc
);

    fetch_state_t state_q, state_d;
    u64           pc_q, pc_d;
    u64           pend_q, pend_d;
    fetch_data_t  buf_q, buf_d;
    pc_sel_t      pc_sel;
    logic         req_valid_q, req_valid_d;
    u64           req_addr_q, req_addr_d;

    fetch_unit_pcselect u_pcselect (
        .sel         (pc_sel),
        .pc_q        (pc_q),
        .redirect_pc (redirect_pc),
        .pend_q      (pend_q),
        .pc_next_c   (pc_d)
    );

    // State, PC, pending target, output buffer and bus request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= REQ;
            pc_q        <= PC_RESET;
            pend_q      <= '0;
            buf_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= PC_RESET;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            buf_q       <= buf_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    // Next-state, buffer and PC-source selection; redirect has top priority.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        buf_d   = buf_q;
        pc_sel  = PC_HOLD;

        unique case (state_q)
            REQ: begin
                if (!req_valid_q) begin
                    // No request on the bus (first cycle after reset, or a
                    // misaligned PC that was never issued).
                    if (redirect_valid) begin
                        pc_sel = PC_REDIR;
                    end
`ifdef FETCH_MISALIGN_CHECK_EN
                    else if (pc_misaligned(pc_q)) begin
                        buf_d   = '{valid: 1'b1, pc: pc_q, instr: '0, exc: 1'b1};
                        state_d = FULL;
                    end
`endif
                end else if (redirect_valid) begin
                    if (ibus.iresp_data_ok) begin
                        // Response and redirect coincide: drop the response.
                        pc_sel = PC_REDIR;
                    end else begin
                        // Request cannot be withdrawn; drain it in DROP.
                        pend_d  = redirect_pc;
                        state_d = DROP;
                    end
                end else if (ibus.iresp_data_ok) begin
                    buf_d   = '{valid: 1'b1, pc: pc_q, instr: ibus.iresp_data, exc: 1'b0};
                    pc_sel  = PC_INC;
                    state_d = FULL;
                end
            end

            FULL: begin
                if (redirect_valid) begin
                    buf_d   = '0;
                    pc_sel  = PC_REDIR;
                    state_d = REQ;
                end else if (flush || id_ready) begin
                    buf_d   = '0;
                    state_d = REQ;
                end
            end

            DROP: begin
                if (redirect_valid && ibus.iresp_data_ok) begin
                    pc_sel  = PC_REDIR;
                    state_d = REQ;
                end else if (redirect_valid) begin
                    // Latest target wins.
                    pend_d = redirect_pc;
                end else if (ibus.iresp_data_ok) begin
                    pc_sel  = PC_PEND;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = REQ;
            end
        endcase

`ifndef FETCH_MISALIGN_CHECK_EN
        buf_d.exc = 1'b0;
`endif
    end

    // Bus request for the next cycle: a new address is only loaded when
    // entering/staying in REQ, so it is stable for the whole handshake.
    always_comb begin
        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;
        if (state_d == DROP) begin
            req_valid_d = 1'b1;
        end else if (state_d == REQ) begin
            req_addr_d = pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            req_valid_d = !pc_misaligned(pc_d);
`else
            req_valid_d = 1'b1;
`endif
        end
    end

    assign ibus.ireq_valid = req_valid_q;
    assign ibus.ireq_addr  = req_addr_q;

    assign fetch_valid = buf_q.valid;
    assign fetch_pc    = buf_q.pc;
    assign fetch_instr = buf_q.instr;
    assign fetch_exc   = buf_q.exc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC and instruction-fetch stage directly upstream of the hazard/decode logic.
- Holds the architectural fetch PC and drives the instruction-bus request/response handshake.
- Applies redirect targets (taken branch, JAL, JALR) and stall commands coming back from the hazard unit.
- Presents one fetched instruction at a time to the IF/ID register through a valid/ready pair.

Parameters:
- PC_RESET, 64'h8000_0000, fetch PC after reset.
- XLEN, 64, PC width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- redirect_valid  in  1  one-cycle pulse: hazard unit resolved a branch/JAL/JALR redirect
- redirect_pc  in  XLEN  redirect target, already masked (JALR bit0 cleared)
- flush  in  1  drop the buffered instruction without changing the PC
- id_ready  in  1  IF/ID accepts the instruction this cycle
- ireq_valid  out  1  instruction-bus request valid
- ireq_addr  out  XLEN  request address
- iresp_data_ok  in  1  response beat valid
- iresp_data  in  INST_W  instruction word
- fetch_valid  out  1  fetch_instr/fetch_pc hold a valid instruction
- fetch_pc  out  XLEN  PC of the presented instruction
- fetch_instr  out  INST_W  presented instruction
- fetch_exc  out  1  misaligned-PC flag (exists only with the optional feature; otherwise tied 0)

Behaviour:
- Reset (async, active-high):
  - pc_q=PC_RESET, state=REQ, pend_q=0.
  - fetch_valid=0, fetch_pc=0, fetch_instr=0, fetch_exc=0.
  - ireq_valid=0 while reset is asserted; asserted the first cycle after release.
- States:
  - REQ: ireq_valid=1, ireq_addr=pc_q.
  - FULL: buffer occupied, ireq_valid=0.
  - DROP: stale request in flight, ireq_valid=1, address unchanged.
- Bus rule: once ireq_valid rises, ireq_addr stays stable and ireq_valid stays high until iresp_data_ok. A request is never withdrawn.
- REQ, on iresp_data_ok with no redirect:
  - Capture instr and pc_q into the output buffer; pc_q<=pc_q+4 (mod 2^XLEN, wraps silently).
  - Go to FULL; fetch_valid=1 from the next cycle.
- FULL:
  - Outputs are held stable while id_ready=0.
  - On id_ready=1: buffer empties, go to REQ, next request is issued the following cycle.
  - Steady-state throughput with a 1-cycle bus is one instruction per 2 cycles.
- Redirect (highest priority, overrides id_ready and flush):
  - REQ without data_ok: latch target into pend_q, go to DROP.
  - REQ with data_ok in the same cycle: discard the response, pc_q<=redirect_pc, stay in REQ (new address issued next cycle).
  - FULL: clear the buffer (fetch_valid=0 next cycle), pc_q<=redirect_pc, go to REQ.
  - DROP: overwrite pend_q (latest target wins).
- DROP, on data_ok: discard the response, pc_q<=pend_q, go to REQ. A redirect in that same cycle uses the new redirect_pc instead of pend_q.
- flush without redirect:
  - FULL: buffer cleared, go to REQ, pc_q unchanged.
  - Ignored in REQ and DROP.
- A discarded response never asserts fetch_valid.
- Reset mid-transaction: state, buffer and pc_q are reinitialised; no response is expected afterwards (the bus is reset together with the core).

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A PC entering REQ with pc[1:0]!=0 issues no bus request.
  - FULL is entered directly with fetch_exc=1, fetch_instr=0, fetch_pc=misaligned PC.
  - pc_q is not advanced; a later redirect recovers.
- Undefined:
  - No check; the fetch_exc port is tied 0.
  - Misaligned addresses go to the bus unchanged.

Decomposition:
- pipes package: fetch_data_t {valid, pc, instr, exc}, fetch_state_t enum {REQ, FULL, DROP}, PC_RESET constant.
- common package: u64, u32.
- Sub-module pcselect (combinational): chooses among pc_q+4, redirect_pc, pend_q and hold for the next pc_q.

Test Plan:
- Reset release, 1-cycle bus, id_ready=1: requests to 0x8000_0000, 0x8000_0004, 0x8000_0008 in cycles 1, 3, 5; fetch_valid pulses in cycles 2, 4, 6 with matching fetch_pc.
- id_ready=0 for 5 cycles while FULL at pc 0x8000_0004: fetch_instr/fetch_pc stable, ireq_valid=0; resumes at 0x8000_0008 after release.
- Redirect to 0x8000_0100 while a 3-cycle response is outstanding:
  - ireq_addr stays at the old value until data_ok.
  - The response is not presented.
  - The next ireq_addr is 0x8000_0100.
- Redirect to 0x8000_0200 in the same cycle as data_ok: the response is dropped and the next request goes to 0x8000_0200.
- Two redirects (0x100, then 0x300) during DROP: fetch resumes at 0x300 only.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x8000_0102: no bus request, fetch_valid=1, fetch_exc=1, fetch_pc=0x8000_0102.
